// File: rtl/mux_rr_arbiter_4.sv
// Purpose: round-robin arbiter sharing one 4:1 x 8-bit mux channel, grants capped at MAX_BURST beats.
// Latency: 1 cycle from req to x_valid; every release costs one idle bubble before the next grant.
// Backpressure: x_ready low holds the current beat, burst count and grant; no ack while stalled.

// Plain 4:1 byte mux; the arbiter's key drives sel.
module mux_32_2_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  input  logic [1:0] sel,
  output logic [7:0] y
);

  // Select one of the four byte inputs.
  always_comb begin
    y = a;
    case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      2'd3:    y = d;
      default: y = a;
    endcase
  end

endmodule

module mux_rr_arbiter_4 #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  input  logic [7:0] data_c,
  input  logic [7:0] data_d,
  input  logic       x_ready,
  output logic [7:0] x,
  output logic       x_valid,
  output logic [3:0] ack,
  output logic [1:0] key,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Count value at which the next beat closes the burst.
  localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] key_nxt;
  logic [1:0] ptr;
  logic [1:0] ptr_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [1:0] pick;
  logic       found;
  logic       beat;
  logic       last_beat;

  // Datapath: x always follows the currently selected requester.
  mux_32_2_8 u_mux (
    .a   (data_a),
    .b   (data_b),
    .c   (data_c),
    .d   (data_d),
    .sel (key),
    .y   (x)
  );

  // Rotating-priority scan: first requester at or after ptr, wrapping 3->0.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr + 2'(k)]) begin
        pick  = ptr + 2'(k);
        found = 1'b1;
      end
    end
  end

  // Handshake outputs; held quiet while reset is asserted so no ack leaks out.
  always_comb begin
    busy      = !rst && (state == GRANT);
    x_valid   = busy && req[key];
    beat      = x_valid && x_ready;
    ack       = beat ? (4'b0001 << key) : 4'b0000;
    last_beat = beat && (cnt == LAST_CNT);
  end

  // Next-state logic: arbitrate in IDLE, count beats and decide release in GRANT.
  always_comb begin
    state_nxt = state;
    key_nxt   = key;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          key_nxt   = pick;
          cnt_nxt   = 8'd0;
        end
      end
      GRANT: begin
        if (beat) begin
          cnt_nxt = cnt + 8'd1;
        end
        // A dropped request cannot coincide with a beat, so the two cases are disjoint.
        if (last_beat || !req[key]) begin
          state_nxt = IDLE;
          ptr_nxt   = key + 2'd1;
          cnt_nxt   = 8'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      key   <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      key   <= key_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter_4.sv
// Purpose: directed self-checking bench for mux_rr_arbiter_4 with MAX_BURST=4.
// Latency: inputs change 1ns after a rising edge, outputs checked 1ns later.
// Backpressure: exercised through directed x_ready stall windows.
module tb_mux_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [7:0] data_c;
  logic [7:0] data_d;
  logic       x_ready;
  logic [7:0] x;
  logic       x_valid;
  logic [3:0] ack;
  logic [1:0] key;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] dat [4];

  mux_rr_arbiter_4 #(.MAX_BURST(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data_a  (data_a),
    .data_b  (data_b),
    .data_c  (data_c),
    .data_d  (data_d),
    .x_ready (x_ready),
    .x       (x),
    .x_valid (x_valid),
    .ack     (ack),
    .key     (key),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and let inputs change 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    settle();
  endtask

  // Expect one accepted beat from requester k in the current cycle.
  task automatic expect_beat(input string tag, input int k);
    check_eq({tag, "_key"}, 32'(key), 32'(k));
    check_eq({tag, "_ack"}, 32'(ack), 32'(4'b0001 << k));
    check_eq({tag, "_x"}, 32'(x), 32'(dat[k]));
  endtask

  // Expect an idle bubble cycle.
  task automatic expect_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_xvalid"}, 32'(x_valid), 32'd0);
    check_eq({tag, "_ack"}, 32'(ack), 32'd0);
  endtask

  initial begin
    data_a  = 8'h11;
    data_b  = 8'h22;
    data_c  = 8'hA5;
    data_d  = 8'h44;
    dat[0]  = 8'h11;
    dat[1]  = 8'h22;
    dat[2]  = 8'hA5;
    dat[3]  = 8'h44;
    x_ready = 1'b1;
    rst     = 1'b1;
    req     = 4'b1111;

    // T1 reset held two cycles with all requesting
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("t1_rst_xvalid", 32'(x_valid), 32'd0);
      check_eq("t1_rst_ack", 32'(ack), 32'd0);
      check_eq("t1_rst_busy", 32'(busy), 32'd0);
      check_eq("t1_rst_key", 32'(key), 32'd0);
    end
    rst = 1'b0;
    settle();
    expect_idle("t1_post_rst");
    step();
    check_eq("t1_first_valid", 32'(x_valid), 32'd1);
    check_eq("t1_first_key", 32'(key), 32'd0);

    // T3 rotation: 0,1,2,3,0 with 4 beats each and one bubble between
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) begin
        expect_beat($sformatf("t3_g%0d_b%0d", g, b), g % 4);
        step();
      end
      expect_idle($sformatf("t3_bubble%0d", g));
      check_eq("t3_key_hold", 32'(key), 32'(g % 4));
      step();
    end

    // T2 single burst from requester 2
    do_reset();
    req = 4'b0100;
    settle();
    expect_idle("t2_idle");
    step();
    for (int b = 0; b < 4; b++) begin
      expect_beat($sformatf("t2_b%0d", b), 2);
      step();
    end
    expect_idle("t2_bubble");
    check_eq("t2_bubble_key", 32'(key), 32'd2);
    step();
    expect_beat("t2_regrant", 2);
    req = 4'b0000;
    settle();
    check_eq("t2_drop_xvalid", 32'(x_valid), 32'd0);
    check_eq("t2_drop_ack", 32'(ack), 32'd0);
    step();
    expect_idle("t2_released");

    // T4 backpressure on requester 1
    do_reset();
    req = 4'b0010;
    step();
    x_ready = 1'b0;
    settle();
    for (int s = 0; s < 3; s++) begin
      check_eq($sformatf("t4_stall%0d_key", s), 32'(key), 32'd1);
      check_eq($sformatf("t4_stall%0d_xvalid", s), 32'(x_valid), 32'd1);
      check_eq($sformatf("t4_stall%0d_ack", s), 32'(ack), 32'd0);
      step();
    end
    x_ready = 1'b1;
    settle();
    for (int b = 0; b < 4; b++) begin
      expect_beat($sformatf("t4_b%0d", b), 1);
      step();
    end
    expect_idle("t4_bubble");

    // T5 early drop of requester 0 after two beats
    do_reset();
    req = 4'b1001;
    step();
    expect_beat("t5_b0", 0);
    step();
    expect_beat("t5_b1", 0);
    step();
    req = 4'b1000;
    settle();
    check_eq("t5_drop_busy", 32'(busy), 32'd1);
    check_eq("t5_drop_xvalid", 32'(x_valid), 32'd0);
    check_eq("t5_drop_ack", 32'(ack), 32'd0);
    step();
    expect_idle("t5_bubble");
    step();
    expect_beat("t5_next", 3);

    // T6 reset mid-grant: ptr moved to 2 beforehand, reset must bring it back to 0
    do_reset();
    req = 4'b0010;
    step();
    for (int b = 0; b < 4; b++) begin
      expect_beat($sformatf("t6_pre_b%0d", b), 1);
      step();
    end
    req = 4'b1111;
    settle();
    expect_idle("t6_pre_bubble");
    step();
    expect_beat("t6_grant2", 2);
    step();
    rst = 1'b1;
    settle();
    check_eq("t6_rst_ack", 32'(ack), 32'd0);
    check_eq("t6_rst_xvalid", 32'(x_valid), 32'd0);
    step();
    rst = 1'b0;
    settle();
    expect_idle("t6_after_rst");
    step();
    expect_beat("t6_regrant", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
